// File: rtl/dcm_rst_seq_pkg.sv
// Shared types and constants for the DCM reset/lock sequencer.
package dcm_rst_seq_pkg;

  localparam int         CNT_W                = 20;
  localparam int         STATUS_CLKFX_STOPPED = 2;
  localparam logic [3:0] RETRY_CNT_MAX        = 4'd15;

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

endpackage

// File: rtl/dcm_rst_seq_sync2.sv
// Two-flop synchronizer with synchronous active-high reset (flops clear to 0).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_rst_seq.sv
// DCM reset/lock sequencer: pulses DCM_RST, waits for a settled lock, then releases SYS_RST.
// Define DCM_STATUS_MON_EN to also treat STATUS[2] (CLKFX stopped) as loss of lock.
module dcm_rst_seq
  import dcm_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int SETTLE_CYCLES    = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic [7:0] STATUS,
  output logic       DCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic [3:0] RETRY_CNT
);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc;
  logic             retry;
  logic             lock_s;
  logic             fxstop_s;
  logic             fault;
  logic             dcm_rst_d, sys_rst_d, ready_d;

  sync2 u_lock_sync (
    .clk (CLK),
    .rst (RST),
    .d   (LOCKED),
    .q   (lock_s)
  );

`ifdef DCM_STATUS_MON_EN
  sync2 u_fxstop_sync (
    .clk (CLK),
    .rst (RST),
    .d   (STATUS[STATUS_CLKFX_STOPPED]),
    .q   (fxstop_s)
  );
  logic [6:0] status_unused;
  assign status_unused = {STATUS[7:3], STATUS[1:0]};
`else
  logic [7:0] status_unused;
  assign status_unused = STATUS;
  assign fxstop_s      = 1'b0;
`endif

  // A stopped CLKFX is indistinguishable from a lost lock once we are past WAIT_LOCK.
  assign fault = !lock_s || fxstop_s;

  // State register, cycle counter, retry counter and registered Moore outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RESET;
      cnt       <= '0;
      RETRY_CNT <= '0;
      DCM_RST   <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + 1'b1;
      if (retry && RETRY_CNT != RETRY_CNT_MAX)
        RETRY_CNT <= RETRY_CNT + 1'b1;
      DCM_RST <= dcm_rst_d;
      SYS_RST <= sys_rst_d;
      READY   <= ready_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b1;
    retry     = 1'b0;
    case (state)
      S_RESET: begin
        if (cnt == PULSE_LAST)
          state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock is checked first so it wins a tie with the timeout.
        if (lock_s) begin
          state_nxt = S_SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_RESET;
          retry     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (fault) begin
          state_nxt = S_RESET;
          retry     = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_inc = 1'b0;
        if (fault) begin
          state_nxt = S_RESET;
          retry     = 1'b1;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Decoded from the next state so outputs move on the same edge as the state register.
  always_comb begin
    dcm_rst_d = (state_nxt == S_RESET);
    sys_rst_d = (state_nxt != S_RUN);
    ready_d   = (state_nxt == S_RUN);
  end

endmodule

// File: tb/tb_dcm_rst_seq.sv
// Directed bench for dcm_rst_seq with RST_PULSE_CYCLES=4, LOCK_TIMEOUT=64, SETTLE_CYCLES=8.
module tb_dcm_rst_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOCKED = 1'b0;
  logic [7:0] STATUS = 8'h00;
  logic       DCM_RST, SYS_RST, READY;
  logic [3:0] RETRY_CNT;

  int checks   = 0;
  int failures = 0;

  dcm_rst_seq #(
    .RST_PULSE_CYCLES (4),
    .LOCK_TIMEOUT     (64),
    .SETTLE_CYCLES    (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOCKED    (LOCKED),
    .STATUS    (STATUS),
    .DCM_RST   (DCM_RST),
    .SYS_RST   (SYS_RST),
    .READY     (READY),
    .RETRY_CNT (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cycles DCM_RST stays high, counting the current one.
  task automatic count_high(output int n);
    n = 0;
    while (DCM_RST === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (DCM_RST === 1'b0 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (READY !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  // Reset with LOCKED already high: 4-cycle pulse, then WAIT(1) + SETTLE(8) = 9 edges to RUN.
  task automatic bring_up(input string tag);
    int n;
    RST = 1'b1; LOCKED = 1'b1; STATUS = 8'h00;
    tick(); tick();
    RST = 1'b0;
    count_high(n);
    chk({tag, "_pulse"}, n, 4);
    wait_ready(n);
    chk({tag, "_ready_lat"}, n, 9);
    chk({tag, "_retry"}, RETRY_CNT, 0);
  endtask

  initial begin
    int n;

    // Power-up
    tick(); tick();
    chk("rst_dcm_rst", DCM_RST, 1);
    chk("rst_sys_rst", SYS_RST, 1);
    chk("rst_ready", READY, 0);
    chk("rst_retry", RETRY_CNT, 0);
    RST = 1'b0;
    count_high(n);
    chk("pwr_pulse", n, 4);
    tick(); tick();
    LOCKED = 1'b1;
    wait_ready(n);
    chk("pwr_ready_lat", n, 11);
    chk("pwr_sys_rst", SYS_RST, 0);
    chk("pwr_dcm_rst", DCM_RST, 0);
    chk("pwr_retry", RETRY_CNT, 0);

    // Loss of lock in RUN: 3-edge latency
    LOCKED = 1'b0;
    tick();
    chk("lol_e1_ready", READY, 1);
    tick();
    chk("lol_e2_ready", READY, 1);
    chk("lol_e2_dcm_rst", DCM_RST, 0);
    tick();
    chk("lol_e3_ready", READY, 0);
    chk("lol_e3_dcm_rst", DCM_RST, 1);
    chk("lol_e3_sys_rst", SYS_RST, 1);
    chk("lol_e3_retry", RETRY_CNT, 1);
    LOCKED = 1'b1;
    wait_ready(n);
    chk("lol_relock_lat", n, 13);
    chk("lol_retry_hold", RETRY_CNT, 1);

    // Glitch at settle count 5
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    repeat (10) tick();
    chk("gl_pre_sys_rst", SYS_RST, 1);
    chk("gl_pre_dcm_rst", DCM_RST, 0);
    LOCKED = 1'b0;
    tick();
    LOCKED = 1'b1;
    chk("gl_e1_sys_rst", SYS_RST, 1);
    tick();
    chk("gl_e2_dcm_rst", DCM_RST, 0);
    chk("gl_e2_ready", READY, 0);
    tick();
    chk("gl_e3_dcm_rst", DCM_RST, 1);
    chk("gl_e3_sys_rst", SYS_RST, 1);
    chk("gl_e3_ready", READY, 0);
    chk("gl_e3_retry", RETRY_CNT, 1);
    wait_ready(n);
    chk("gl_recover_lat", n, 13);

    // Second retry, then RST at settle count 3
    LOCKED = 1'b0;
    tick(); tick(); tick();
    chk("mid_retry2", RETRY_CNT, 2);
    chk("mid_dcm_rst", DCM_RST, 1);
    LOCKED = 1'b1;
    repeat (8) tick();
    chk("mid_settle_dcm_rst", DCM_RST, 0);
    chk("mid_settle_sys_rst", SYS_RST, 1);
    RST = 1'b1;
    tick();
    chk("mid_rst_dcm_rst", DCM_RST, 1);
    chk("mid_rst_retry", RETRY_CNT, 0);
    chk("mid_rst_ready", READY, 0);
    tick();
    RST = 1'b0;
    count_high(n);
    chk("mid_pulse", n, 4);
    wait_ready(n);
    chk("mid_ready_lat", n, 9);

    // STATUS monitoring
    bring_up("feat");
    STATUS = 8'hFB;
    repeat (5) tick();
    chk("feat_other_bits_ready", READY, 1);
    STATUS = 8'h04;
    tick(); tick();
    chk("feat_e2_ready", READY, 1);
    tick();
`ifdef DCM_STATUS_MON_EN
    chk("feat_e3_ready", READY, 0);
    chk("feat_e3_dcm_rst", DCM_RST, 1);
    chk("feat_e3_retry", RETRY_CNT, 1);
`else
    chk("feat_e3_ready", READY, 1);
    chk("feat_e3_dcm_rst", DCM_RST, 0);
    chk("feat_e3_retry", RETRY_CNT, 0);
`endif
    STATUS = 8'h00;

    // No lock: 4 high + 64 low per retry, saturating at 15
    LOCKED = 1'b0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    count_high(n);
    chk("nl_pulse0", n, 4);
    chk("nl_retry0", RETRY_CNT, 0);
    for (int r = 1; r <= 16; r++) begin
      count_low(n);
      chk($sformatf("nl_low%0d", r), n, 64);
      chk($sformatf("nl_retry%0d", r), RETRY_CNT, (r > 15) ? 15 : r);
      count_high(n);
      chk($sformatf("nl_pulse%0d", r), n, 4);
    end
    chk("nl_sys_rst", SYS_RST, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
